// File: rtl/seg7_pkg.sv
// Shared constants for the 7-segment scan controller: active-low hex glyphs (bit 6 = g, bit 0 = a)
// and the digit index width helper.
package seg7_pkg;

  localparam logic [6:0] SEG_BLANK = 7'h7F;

  localparam logic [6:0] HEX_SEG [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

  function automatic int idx_w(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/seg7_hex_decode.sv
// Nibble to active-low 7-segment glyph (0-9, A b C d E F), purely combinational.
module seg7_hex_decode
  import seg7_pkg::*;
(
  input  logic [3:0] nib_i,
  output logic [6:0] seg_o
);

  assign seg_o = HEX_SEG[nib_i];

endmodule

// File: rtl/seg7_scan_ctrl.sv
// N-digit multiplexed 7-segment scan controller with blanking, frame-synchronous value update,
// blank mask and DP. Optional leading-zero suppression when SEG7_LZS_EN is defined.
module seg7_scan_ctrl
  import seg7_pkg::*;
#(
  parameter int N_DIGITS  = 4,
  parameter int CLK_DIV   = 100000,
  parameter int BLANK_CYC = 1000
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  enable,
  input  logic [4*N_DIGITS-1:0] val_in,
  input  logic                  val_valid,
  input  logic [N_DIGITS-1:0]   dp_in,
  input  logic [N_DIGITS-1:0]   blank_mask,
  output logic [N_DIGITS-1:0]   an,
  output logic [6:0]            segs,
  output logic                  dp,
  output logic                  frame_start
);

  localparam int CW = $clog2(CLK_DIV);
  localparam int IW = idx_w(N_DIGITS);

  logic [CW-1:0]         cnt_q, cnt_d;
  logic [IW-1:0]         idx_q, idx_d;
  logic [4*N_DIGITS-1:0] disp_q, disp_d, pend_q, pend_d;
  logic                  pend_vld_q, pend_vld_d;
  logic [N_DIGITS-1:0]   an_q, an_d;
  logic [6:0]            segs_q, segs_d;
  logic                  dp_q, dp_d, fs_q;
  logic                  slot_end, wrap, past_blank, lit;
  logic [N_DIGITS-1:0]   sup;
  logic [6:0]            pat [N_DIGITS];

  always_comb begin
    slot_end   = (cnt_q == CW'(CLK_DIV - 1));
    wrap       = slot_end && (idx_q == IW'(N_DIGITS - 1));
    cnt_d      = slot_end ? '0 : cnt_q + CW'(1);
    idx_d      = idx_q;
    disp_d     = disp_q;
    pend_d     = pend_q;
    pend_vld_d = pend_vld_q;
    if (slot_end) idx_d = wrap ? '0 : idx_q + IW'(1);
    // New values only reach the display at the frame wrap; a strobe on the wrap itself bypasses pend.
    if (wrap) begin
      pend_vld_d = 1'b0;
      if (val_valid)       disp_d = val_in;
      else if (pend_vld_q) disp_d = pend_q;
    end else if (val_valid) begin
      pend_d     = val_in;
      pend_vld_d = 1'b1;
    end
  end

`ifdef SEG7_LZS_EN
  // A digit is suppressed when it and every digit above it are zero; digit 0 always shows.
  always_comb begin
    logic run;
    run = 1'b1;
    sup = '0;
    for (int i = N_DIGITS - 1; i > 0; i--) begin
      run    = run & (disp_q[4*i +: 4] == 4'h0);
      sup[i] = run;
    end
  end
`else
  assign sup = '0;
`endif

  for (genvar g = 0; g < N_DIGITS; g++) begin : g_dec
    seg7_hex_decode u_dec (
      .nib_i (disp_q[4*g +: 4]),
      .seg_o (pat[g])
    );
  end

  if (BLANK_CYC == 0) begin : g_noblank
    assign past_blank = 1'b1;
  end else begin : g_blank
    assign past_blank = (cnt_q >= CW'(BLANK_CYC));
  end

  always_comb begin
    lit    = enable && past_blank && !blank_mask[idx_q] && !sup[idx_q];
    an_d   = lit ? ~(N_DIGITS'(1) << idx_q) : '1;
    segs_d = pat[idx_q];
    dp_d   = ~(dp_in[idx_q] && lit);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q      <= '0;
      idx_q      <= '0;
      disp_q     <= '0;
      pend_q     <= '0;
      pend_vld_q <= 1'b0;
      an_q       <= '1;
      segs_q     <= SEG_BLANK;
      dp_q       <= 1'b1;
      fs_q       <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      idx_q      <= idx_d;
      disp_q     <= disp_d;
      pend_q     <= pend_d;
      pend_vld_q <= pend_vld_d;
      an_q       <= an_d;
      segs_q     <= segs_d;
      dp_q       <= dp_d;
      fs_q       <= wrap;
    end
  end

  assign an          = an_q;
  assign segs        = segs_q;
  assign dp          = dp_q;
  assign frame_start = fs_q;

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Scoreboard bench for seg7_scan_ctrl (N_DIGITS=4, CLK_DIV=8, BLANK_CYC=2); follows SEG7_LZS_EN.
module tb_seg7_scan_ctrl;

  localparam int N  = 4;
  localparam int CD = 8;
  localparam int BC = 2;

  typedef struct packed {
    logic [3:0] an;
    logic [6:0] segs;
    logic       dp;
    logic       fs;
  } exp_t;

  // Glyphs written out as segment sets (g..a, 0 = on)
  localparam logic [6:0] GLYPH [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
  };

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        enable = 1'b0;
  logic [15:0] val_in = '0;
  logic        val_valid = 1'b0;
  logic [3:0]  dp_in = '0;
  logic [3:0]  blank_mask = '0;
  logic [3:0]  an;
  logic [6:0]  segs;
  logic        dp;
  logic        frame_start;

  seg7_scan_ctrl #(.N_DIGITS(N), .CLK_DIV(CD), .BLANK_CYC(BC)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .enable      (enable),
    .val_in      (val_in),
    .val_valid   (val_valid),
    .dp_in       (dp_in),
    .blank_mask  (blank_mask),
    .an          (an),
    .segs        (segs),
    .dp          (dp),
    .frame_start (frame_start)
  );

  always #5 clk = ~clk;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc      = 0;

  // Reference model: elapsed cycles since reset plus the displayed / pending values.
  int          t = 0;
  logic [15:0] m_disp = '0, m_pend = '0;
  bit          m_pvld = 1'b0;

  function automatic bit suppressed(input int d, input logic [15:0] v);
`ifdef SEG7_LZS_EN
    return (d > 0) && ((v >> (4 * d)) == 16'h0);
`else
    return 1'b0;
`endif
  endfunction

  task automatic chk(input string nm, input logic [6:0] got, input logic [6:0] want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %h expected %h", nm, cyc, got, want);
    end
  endtask

  always @(posedge clk) begin
    exp_t e;
    cyc++;
    #1;
    if (sb.size() != 0) begin
      e = sb.pop_front();
      chk("an",          {3'b0, an},          {3'b0, e.an});
      chk("segs",        segs,                e.segs);
      chk("dp",          {6'b0, dp},          {6'b0, e.dp});
      chk("frame_start", {6'b0, frame_start}, {6'b0, e.fs});
    end
  end

  task automatic step(input bit rst, input bit en, input bit vv, input logic [15:0] v,
                      input logic [3:0] dpi, input logic [3:0] msk);
    exp_t e;
    int   dig, phase;
    bit   lit, wrap;
    @(negedge clk);
    rst_n = ~rst; enable = en; val_valid = vv; val_in = v; dp_in = dpi; blank_mask = msk;
    if (rst) begin
      e = '{an: 4'hF, segs: 7'h7F, dp: 1'b1, fs: 1'b0};
      t = 0; m_disp = '0; m_pend = '0; m_pvld = 1'b0;
    end else begin
      phase = t % CD;
      dig   = (t / CD) % N;
      wrap  = (t % (CD * N)) == (CD * N - 1);
      lit   = en && (phase >= BC) && !msk[dig] && !suppressed(dig, m_disp);
      for (int i = 0; i < N; i++) e.an[i] = !(lit && (i == dig));
      e.segs = GLYPH[(m_disp >> (4 * dig)) & 16'hF];
      e.dp   = !(dpi[dig] && lit);
      e.fs   = wrap;
      if (wrap) begin
        if (vv)          m_disp = v;
        else if (m_pvld) m_disp = m_pend;
        m_pvld = 1'b0;
      end else if (vv) begin
        m_pend = v; m_pvld = 1'b1;
      end
      t++;
    end
    sb.push_back(e);
  endtask

  task automatic run(input int n, input bit en, input logic [3:0] dpi, input logic [3:0] msk);
    for (int k = 0; k < n; k++) step(1'b0, en, 1'b0, val_in, dpi, msk);
  endtask

  // Advance (bounded) until the model sits at cycle `ph` of digit slot `d`.
  task automatic seek(input int d, input int ph);
    for (int k = 0; k < CD * N; k++) begin
      if (((t / CD) % N) == d && (t % CD) == ph) break;
      step(1'b0, 1'b1, 1'b0, val_in, 4'h0, 4'h0);
    end
  endtask

  initial begin
    repeat (3) step(1'b1, 1'b0, 1'b0, 16'h0, 4'h0, 4'h0);
    step(1'b0, 1'b1, 1'b1, 16'h1234, 4'h0, 4'h0);
    run(70, 1'b1, 4'h0, 4'h0);

    seek(2, 3);
    step(1'b0, 1'b1, 1'b1, 16'hABCD, 4'h0, 4'h0);
    run(45, 1'b1, 4'h0, 4'h0);

    step(1'b0, 1'b1, 1'b1, 16'h1111, 4'h0, 4'h0);
    seek(3, CD - 1);
    step(1'b0, 1'b1, 1'b1, 16'h5A5A, 4'h0, 4'h0);
    run(40, 1'b1, 4'h0, 4'h0);

    run(40, 1'b1, 4'b0001, 4'b0100);
    run(12, 1'b0, 4'b0001, 4'b0000);
    run(20, 1'b1, 4'b1010, 4'b0000);

    seek(1, 4);
    step(1'b0, 1'b1, 1'b1, 16'h0F0F, 4'h0, 4'h0);
    seek(2, 3);
    step(1'b1, 1'b1, 1'b0, 16'h0, 4'h0, 4'h0);
    run(70, 1'b1, 4'h0, 4'h0);

    step(1'b0, 1'b1, 1'b1, 16'h0005, 4'h0, 4'h0);
    run(70, 1'b1, 4'h0, 4'h0);
    step(1'b0, 1'b1, 1'b1, 16'h0000, 4'h0, 4'h0);
    run(70, 1'b1, 4'h0, 4'h0);
    step(1'b0, 1'b1, 1'b1, 16'h0230, 4'h0, 4'h0);
    run(70, 1'b1, 4'h0, 4'h0);

    for (int k = 0; k < 1200; k++) begin
      step($urandom_range(0, 199) == 0, $urandom_range(0, 7) != 0,
           $urandom_range(0, 15) == 0, 16'($urandom),
           4'($urandom), ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'h0);
    end

    repeat (2) @(negedge clk);
    n_checks++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d entries left expected 0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
